// File: rtl/pending_prio_pkg.sv
// Shared constants, state encoding and priority helper for the pending priority encoder.
// Latency: none (package only).
// Backpressure: not applicable.
package pending_prio_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;
  localparam int CNT_W  = 8;
  localparam int POP_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Highest set index wins; an all-zero vector maps to code 0.
  function automatic logic [CODE_W-1:0] prio_code(input logic [N_REQ-1:0] v);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) c = CODE_W'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_prio_enc_4to2.sv
// Highest-index priority encoder over four lines with an any-set flag.
// Latency: purely combinational.
// Backpressure: none; output follows the input vector.
module prio_enc_4to2
  import pending_prio_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              any_set
);

  // Encode the highest set bit and flag whether any bit is set.
  always_comb begin
    code    = prio_code(vec);
    any_set = |vec;
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky request capture with highest-index code presentation over valid/ready.
// Latency: req sampled at edge k is presented as out_valid/out_code right after edge k.
// Backpressure: out_code holds while out_ready=0; new requests wait in pending, no preemption.
module pending_priority_encoder
  import pending_prio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_REQ-1:0]  req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic [N_REQ-1:0]  pending,
  output logic [CNT_W-1:0]  missed_cnt
);

  state_t             state;
  state_t             state_nxt;
  logic [N_REQ-1:0]   req_m;
  logic               acc;
  logic [N_REQ-1:0]   clr;
  logic [N_REQ-1:0]   clr_eff;
  logic [N_REQ-1:0]   next_set;
  logic [N_REQ-1:0]   miss_vec;
  logic [CODE_W-1:0]  enc_code;
  logic               any_set;
  logic               load;
  logic [POP_W-1:0]   miss_inc;
  logic [CNT_W:0]     miss_sum;
  logic [CNT_W-1:0]   missed_nxt;

  assign req_m    = enable ? req : '0;
  assign acc      = out_valid & out_ready;
  assign clr      = acc ? (N_REQ'(1) << out_code) : '0;
  // A request landing on the bit being retired keeps it pending.
  assign clr_eff  = clr & ~req_m;
  assign next_set = (pending | req_m) & ~clr_eff;
  // Requests on the retiring bit are re-arms, not misses.
  assign miss_vec = req_m & pending & ~clr;
  assign out_valid = (state == HOLD);

  prio_enc_4to2 u_prio_enc (
    .vec     (next_set),
    .code    (enc_code),
    .any_set (any_set)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: enter HOLD on any work, leave only when an accept drains everything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_set) state_nxt = HOLD;
      HOLD:    if (acc && !any_set) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output control: a new code is loaded from IDLE or right after an accept.
  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:    load = any_set;
      HOLD:    load = acc && any_set;
      default: load = 1'b0;
    endcase
  end

  // Popcount the missed requests and saturate the running total.
  always_comb begin
    miss_inc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      miss_inc = miss_inc + POP_W'(miss_vec[i]);
    end
    miss_sum = {1'b0, missed_cnt} + (CNT_W+1)'(miss_inc);
    missed_nxt = miss_sum[CNT_W] ? {CNT_W{1'b1}} : miss_sum[CNT_W-1:0];
  end

  // Pending bits, presented code and missed counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      out_code   <= '0;
      missed_cnt <= '0;
    end else begin
      pending    <= next_set;
      missed_cnt <= missed_nxt;
      if (load) out_code <= enc_code;
    end
  end

endmodule

// File: tb/tb_pending_priority_encoder.sv
module tb_pending_priority_encoder;
  import pending_prio_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [1:0] out_code;
  logic [3:0] pending;
  logic [7:0] missed_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state (behavioural, per-bit arrays and integers).
  bit m_pend[4];
  bit m_valid;
  int m_code;
  int m_missed;

  pending_priority_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req        (req),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_code   (out_code),
    .pending    (pending),
    .missed_cnt (missed_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_valid  = 1'b0;
    m_code   = 0;
    m_missed = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit np[4];
    bit acc;
    int cnt;
    bit r;
    bit retire;
    acc = m_valid && out_ready;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      r      = enable && req[i];
      retire = acc && (i == m_code);
      if (r && m_pend[i] && !retire) cnt++;
      np[i] = r || (m_pend[i] && !retire);
    end
    m_missed = (m_missed + cnt > 255) ? 255 : m_missed + cnt;
    if (!m_valid || acc) begin
      m_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (np[i]) begin
          m_valid = 1'b1;
          m_code  = i;
        end
      end
    end
    for (int i = 0; i < 4; i++) m_pend[i] = np[i];
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || pending !== 4'b0000 || missed_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_initial: valid=%b pending=%b missed=%0d, want 0/0000/0", out_valid, pending, missed_cnt);
    end
    enable = 1'b1; req = 4'b1010; out_ready = 1'b0;
    cycle();
    cycle();
    req = 4'b0000;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 2'd3 || pending !== 4'b1010 || missed_cnt !== 8'd2) begin
      errors++;
      $display("FAIL reset_prehold: valid=%b code=%0d pending=%b missed=%0d, want 1/3/1010/2", out_valid, out_code, pending, missed_cnt);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_code !== 2'd0 || pending !== 4'b0000 || missed_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: valid=%b code=%0d pending=%b missed=%0d, want all 0", out_valid, out_code, pending, missed_cnt);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    enable = 1'b1; req = 4'b0100; out_ready = 1'b1;
    cycle();
    req = 4'b0000;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 2'd2) begin
      errors++;
      $display("FAIL single_present: valid=%b code=%0d, want 1/2", out_valid, out_code);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_drain: valid=%b pending=%b, want 0/0000", out_valid, pending);
    end
  endtask

  task automatic test_priority_backpressure();
    logic [1:0] exp_seq [3];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd3; exp_seq[2] = 2'd0;
    enable = 1'b1; req = 4'b0011; out_ready = 1'b0;
    cycle();
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_code !== 2'd1) begin
        errors++;
        $display("FAIL prio_hold[%0d]: valid=%b code=%0d, want 1/1", c, out_valid, out_code);
      end
      cycle();
    end
    req = 4'b1000;
    cycle();
    req = 4'b0000;
    checks++;
    if (out_code !== 2'd1 || pending !== 4'b1011) begin
      errors++;
      $display("FAIL prio_no_preempt: code=%0d pending=%b, want 1/1011", out_code, pending);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_code !== exp_seq[c]) begin
        errors++;
        $display("FAIL prio_seq[%0d]: valid=%b code=%0d, want 1/%0d", c, out_valid, out_code, exp_seq[c]);
      end
      cycle();
    end
    checks++;
    if (out_valid !== 1'b0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL prio_end: valid=%b pending=%b, want 0/0000", out_valid, pending);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    enable = 1'b1; req = 4'b0001; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_code !== 2'd0 || missed_cnt !== 8'd0) begin
        errors++;
        $display("FAIL setwins[%0d]: valid=%b code=%0d missed=%0d, want 1/0/0", c, out_valid, out_code, missed_cnt);
      end
    end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) cycle();
    checks++;
    if (missed_cnt !== 8'd5 || missed_cnt !== 8'(m_missed)) begin
      errors++;
      $display("FAIL setwins_missed: missed=%0d, want 5 (model %0d)", missed_cnt, m_missed);
    end
    req = 4'b0000;
  endtask

  task automatic test_enable_gating();
    do_reset();
    enable = 1'b1; req = 4'b0010; out_ready = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_code !== 2'd1 || pending !== 4'b0010) begin
      errors++;
      $display("FAIL enable_setup: valid=%b code=%0d pending=%b, want 1/1/0010", out_valid, out_code, pending);
    end
    enable = 1'b0; req = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0 || pending !== 4'b0000 || missed_cnt !== 8'd0) begin
        errors++;
        $display("FAIL enable_gate[%0d]: valid=%b pending=%b missed=%0d, want 0/0000/0", c, out_valid, pending, missed_cnt);
      end
    end
    enable = 1'b1; req = 4'b0000;
  endtask

  task automatic test_saturation();
    do_reset();
    enable = 1'b1; req = 4'b0001; out_ready = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      cycle();
      if (c == 200) begin
        checks++;
        if (missed_cnt !== 8'd199 || missed_cnt !== 8'(m_missed)) begin
          errors++;
          $display("FAIL sat_mid: missed=%0d, want 199 (model %0d)", missed_cnt, m_missed);
        end
      end
    end
    checks++;
    if (missed_cnt !== 8'd255 || missed_cnt !== 8'(m_missed)) begin
      errors++;
      $display("FAIL sat_final: missed=%0d, want 255 (model %0d)", missed_cnt, m_missed);
    end
    req = 4'b0000;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      enable    = ($urandom_range(0, 7) != 0);
      req       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      checks++;
      if (pending !== m_pend_vec() || out_valid !== m_valid || missed_cnt !== 8'(m_missed) ||
          (m_valid && out_code !== 2'(m_code))) begin
        errors++;
        $display("FAIL random[%0d]: pending=%b valid=%b code=%0d missed=%0d, want %b/%b/%0d/%0d",
                 c, pending, out_valid, out_code, missed_cnt, m_pend_vec(), m_valid, m_code, m_missed);
      end
      checks++;
      if (out_valid === 1'b1 && pending[out_code] !== 1'b1) begin
        errors++;
        $display("FAIL invariant[%0d]: pending=%b code=%0d, want pending[code]=1", c, pending, out_code);
      end
    end
    enable = 1'b1; req = 4'b0000; out_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_priority_backpressure();
    test_set_wins();
    test_enable_gating();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pending_priority_encoder.md
Name: pending_priority_encoder

Overview:
- Sequential counterpart of the 2-to-4 decoder with enable: converts one-hot/multi-hot request lines back into a binary code.
- Request lines are captured into a sticky pending register.
- The highest-index pending request is presented as a 2-bit code over a valid/ready handshake.
- Each code is retired on acceptance.
- Sits upstream of the decoder, so that a code accepted here and fed back through the decoder reproduces the original request line.

Parameters:
- N_REQ, 4, number of request lines. Fixed at 4 for this revision.
- CODE_W, 2, output code width; equals clog2(N_REQ).
- CNT_W, 8, width of the saturating missed-request counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- enable  input  1  1 = sample req; 0 = ignore req (drain continues)
- req  input  N_REQ  request lines, level-sampled each cycle
- out_ready  input  1  consumer accepts out_code this cycle
- out_valid  output  1  out_code holds a valid code
- out_code  output  CODE_W  binary index of the presented request
- pending  output  N_REQ  current sticky pending register
- missed_cnt  output  CNT_W  saturating count of requests that hit an already-pending bit

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending=0, out_valid=0, out_code=0, missed_cnt=0, state=IDLE.
  - Deassertion takes effect at the next clk edge.
  - Reset mid-handshake discards the presented code and all pending bits.
- Definitions:
  - req_m = enable ? req : 0.
  - acc = out_valid & out_ready.
  - clr = acc ? onehot(out_code) : 0.
- Pending update each edge: pending <= (pending | req_m) & ~clr_eff, where clr_eff = clr & ~req_m.
  - Set wins: a req on the bit being retired in the same cycle keeps that bit pending.
- Priority: highest index wins (bit 3 > 2 > 1 > 0). Code of bit i = i.
- State machine, two states:
  - IDLE (out_valid=0):
    - If next_set = (pending | req_m) is nonzero, load out_code = prio(next_set), set out_valid=1, go to HOLD.
    - Otherwise stay in IDLE.
    - Latency: req high at edge k gives out_valid=1 immediately after edge k.
  - HOLD (out_valid=1):
    - out_code is stable while out_ready=0. A higher-priority request arriving meanwhile does not preempt; it waits in pending.
    - On acc, compute next_set = (pending | req_m) & ~clr_eff.
    - If next_set is nonzero, load out_code = prio(next_set) and stay in HOLD, with out_valid held at 1. This gives back-to-back transfers, one code per cycle.
    - If next_set is zero, set out_valid=0 and go to IDLE.
- Invariant: whenever out_valid=1, pending[out_code]=1.
- missed_cnt:
  - Increments by popcount(req_m & pending & ~clr).
  - Saturates at 2^CNT_W-1; never wraps.
  - Requests on the bit being retired that cycle are not counted as missed.
- enable=0:
  - req is ignored entirely (no set, no missed count).
  - Draining of already-pending codes continues normally.
- out_ready while out_valid=0 has no effect.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package pending_prio_pkg:
  - N_REQ, CODE_W, CNT_W constants.
  - State enum {IDLE, HOLD}.
  - Function prio_code(N_REQ-bit vector), returning a CODE_W code.
- One natural sub-module: prio_enc_4to2, a combinational highest-index priority encoder with an any_set output. It is instantiated for next_set selection.

Test Plan:
- Reset check: assert rst_n=0 mid-HOLD with pending=4'b1010. Required: pending=0, out_valid=0, out_code=0, missed_cnt=0 immediately, without waiting for a clk edge.
- Single request: enable=1, req=4'b0100 for one cycle, out_ready=1. Required: out_valid=1 and out_code=2 after that edge; accepted next edge; then out_valid=0 and pending=0.
- Priority with backpressure: pulse req=4'b0011, hold out_ready=0 for 3 cycles, then pulse req=4'b1000, then set out_ready=1 and hold it. Required: out_code stays 1 while backpressured (no preemption); then codes 1, 3, 0 are presented on consecutive cycles; then out_valid=0.
- Set-wins and missed count: hold req=4'b0001 continuously with out_ready=1. Required: out_code=0 is re-presented every cycle, out_valid stays 1, missed_cnt stays 0. Then set out_ready=0 for 5 cycles. Required: missed_cnt=5.
- Enable gating: enable=0, req=4'b1111 for 4 cycles with pending=4'b0010 and out_ready=1. Required: code 1 drains; then out_valid=0, pending=0, missed_cnt unchanged.
- Saturation: with out_ready=0 and bit 0 pending, hold req=4'b0001 for 300 cycles. Required: missed_cnt=255, with no wrap.
